// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared state encoding and sizing helper
// for the parallel-in/serial-out transmitter.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter width; never below one bit.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: WIDTH-bit loadable shift register, serial out.
// Ports: clk, reset (async low), load, shift, din, sout.
module piso_shift_reg
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  // Zeros fill behind the data, so the final shift
  // leaves the line low after the last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      if (MSB_FIRST) q <= {q[WIDTH-2:0], 1'b0};
      else           q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign sout = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: ready/valid word in, one bit per shift_en out.
// Ports: clk, reset, load_valid/load_data/load_ready, shift_en, sdata, sframe, done.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sdata,
  output logic             sframe,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rdy_n, frame_n, done_n;
  logic          load, shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      load_ready <= 1'b0;
      sframe     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      load_ready <= rdy_n;
      sframe     <= frame_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rdy_n   = load_ready;
    frame_n = sframe;
    done_n  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (load_valid && load_ready) begin
          state_n = SHIFT;
          rdy_n   = 1'b0;
          frame_n = 1'b1;
          cnt_n   = '0;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          shift = 1'b1;
          if (cnt == LAST) begin
            state_n = IDLE;
            frame_n = 1'b0;
            done_n  = 1'b1;
            rdy_n   = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (load_data),
    .sout  (sdata)
  );

endmodule
